aesha_result_unloader: RTL and testbench

AESHA_RESULT_UNLOADER -- requirements
Module: aesha_result_unloader

---
 rtl/aesha_result_unloader.sv | 121 ++++++++++++
 tb/tb_aesha_result_unloader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aesha_result_unloader.sv
// ============================================================================
// Module   : aesha_result_unloader
// Brief    : Captures a finished AESHA result and streams it out MSW-first as
//            32-bit words over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aesha_result_unloader #(
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [511:0]      i_core_data,
    input  logic              i_core_done,
    input  logic              i_aes_or_keccak,
    output logic [WORD_W-1:0] o_word,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic [3:0]        o_word_idx,
    output logic              o_busy,
    output logic              o_overrun,
    output logic [7:0]        o_result_cnt
);

    localparam logic [0:0] S_IDLE        = 1'b0;
    localparam logic [0:0] S_STREAM      = 1'b1;
    localparam logic [3:0] C_LAST_AES    = 4'd3;
    localparam logic [3:0] C_LAST_KECCAK = 4'd15;
    localparam logic [3:0] C_AES_BASE    = 4'd12;

    logic [0:0]        r_state;
    logic              r_done_q;
    logic [511:0]      r_buffer;
    logic              r_mode;
    logic [3:0]        r_idx;
    logic              r_overrun;
    logic [7:0]        r_result_cnt;

    logic              w_capture;
    logic              w_streaming;
    logic              w_handshake;
    logic              w_last;
    logic              w_final;
    logic [3:0]        w_last_idx;
    logic [3:0]        w_sel;
    logic [WORD_W-1:0] w_words [16];

    // Slot k holds the k-th most significant word of the full buffer.
    generate
        for (genvar k = 0; k < 16; k++) begin : g_words
            assign w_words[k] = r_buffer[511 - WORD_W*k -: WORD_W];
        end
    endgenerate

    // An AES result occupies the low 128 bits, i.e. the last four slots.
    assign w_sel       = r_mode ? (C_AES_BASE + r_idx) : r_idx;
    assign w_last_idx  = r_mode ? C_LAST_AES : C_LAST_KECCAK;
    assign w_capture   = i_core_done & ~r_done_q;
    assign w_streaming = (r_state == S_STREAM);
    assign w_last      = w_streaming && (r_idx == w_last_idx);
    assign w_handshake = w_streaming & i_ready;
    assign w_final     = w_handshake & w_last;

    assign o_word       = w_streaming ? w_words[w_sel] : '0;
    assign o_valid      = w_streaming;
    assign o_busy       = w_streaming;
    assign o_last       = w_last;
    assign o_word_idx   = r_idx;
    assign o_overrun    = r_overrun;
    assign o_result_cnt = r_result_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_done_q     <= 1'b0;
            r_buffer     <= '0;
            r_mode       <= 1'b0;
            r_idx        <= 4'd0;
            r_overrun    <= 1'b0;
            r_result_cnt <= 8'd0;
        end else begin
            r_done_q <= i_core_done;
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_buffer <= i_core_data;
                        r_mode   <= i_aes_or_keccak;
                        r_idx    <= 4'd0;
                        r_state  <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_final) begin
                        r_result_cnt <= r_result_cnt + 8'd1;
                        r_idx        <= 4'd0;
                        // A new result arriving on the final beat follows without a gap.
                        if (w_capture) begin
                            r_buffer <= i_core_data;
                            r_mode   <= i_aes_or_keccak;
                        end else begin
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        if (w_handshake) begin
                            r_idx <= r_idx + 4'd1;
                        end
                        if (w_capture) begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aesha_result_unloader.sv
// ============================================================================
// Module   : tb_aesha_result_unloader
// Brief    : Randomised scoreboard bench for aesha_result_unloader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aesha_result_unloader;

    logic         clk = 1'b0;
    logic         i_reset;
    logic [511:0] i_core_data;
    logic         i_core_done;
    logic         i_aes_or_keccak;
    logic [31:0]  o_word;
    logic         o_valid;
    logic         i_ready;
    logic         o_last;
    logic [3:0]   o_word_idx;
    logic         o_busy;
    logic         o_overrun;
    logic [7:0]   o_result_cnt;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_cnt = 8'd0;
    logic       exp_overrun = 1'b0;
    int         ready_pct = 100;
    int         n_checks = 0;
    int         n_errors = 0;

    aesha_result_unloader #(.WORD_W(32)) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_core_data     (i_core_data),
        .i_core_done     (i_core_done),
        .i_aes_or_keccak (i_aes_or_keccak),
        .o_word          (o_word),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_last          (o_last),
        .o_word_idx      (o_word_idx),
        .o_busy          (o_busy),
        .o_overrun       (o_overrun),
        .o_result_cnt    (o_result_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a result is a big number cut into 32-bit words, MSW first.
    task automatic push_result(input logic [511:0] data, input logic aes);
        int n = aes ? 4 : 16;
        logic [511:0] src = aes ? {384'd0, data[127:0]} : data;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.word = 32'(src >> (32 * (n - 1 - k)));
            e.idx  = 4'(k);
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    // Ready driver: percentage-controlled random i_ready, changed on negedge.
    initial begin
        i_ready = 1'b0;
        forever begin
            @(negedge clk);
            i_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: samples mid-low-phase, pops the scoreboard on each handshake.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_word  = '0;
        logic [3:0]  prev_idx   = '0;
        logic        prev_last  = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (i_reset !== 1'b1) begin
                prev_stall = 1'b0;
                continue;
            end
            check("result_cnt", 32'(o_result_cnt), 32'(exp_cnt));
            check("overrun", 32'(o_overrun), 32'(exp_overrun));
            check("busy_vs_valid", 32'(o_busy), 32'(o_valid));
            if (prev_stall) begin
                check("hold_valid", 32'(o_valid), 32'd1);
                check("hold_word", o_word, prev_word);
                check("hold_idx", 32'(o_word_idx), 32'(prev_idx));
                check("hold_last", 32'(o_last), 32'(prev_last));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", o_word, 32'hxxxxxxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("word", o_word, e.word);
                    check("word_idx", 32'(o_word_idx), 32'(e.idx));
                    check("last", 32'(o_last), 32'(e.last));
                    if (e.last) exp_cnt = exp_cnt + 8'd1;
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_word  = o_word;
            prev_idx   = o_word_idx;
            prev_last  = o_last;
        end
    end

    task automatic check_reset_outputs();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);
        check("rst_cnt", 32'(o_result_cnt), 32'd0);
        check("rst_word", o_word, 32'd0);
        check("rst_idx", 32'(o_word_idx), 32'd0);
    endtask

    task automatic apply_reset();
        i_reset = 1'b0;
        exp_q.delete();
        exp_cnt     = 8'd0;
        exp_overrun = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        i_reset = 1'b1;
    endtask

    // One-cycle done pulse; 'captured' says whether the DUT should take it.
    task automatic pulse(input logic [511:0] data, input logic aes,
                         input logic captured, input logic chk_lat);
        i_core_data     = data;
        i_aes_or_keccak = aes;
        i_core_done     = 1'b1;
        if (captured) push_result(data, aes);
        @(negedge clk);
        i_core_done = 1'b0;
        if (chk_lat) begin
            #1;
            check("latency_valid", 32'(o_valid), 32'd1);
            check("latency_idx", 32'(o_word_idx), 32'd0);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_idx(input logic [3:0] idx, input logic want_last);
        int n = 0;
        while (!(o_valid && (want_last ? o_last : (o_word_idx == idx))) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        logic [511:0] d;
        logic [511:0] d2;
        i_reset         = 1'b0;
        i_core_data     = '0;
        i_core_done     = 1'b0;
        i_aes_or_keccak = 1'b0;
        @(negedge clk);
        apply_reset();
        @(negedge clk);

        // Keccak counting pattern, ready always high.
        for (int k = 0; k < 16; k++) d[511 - 32*k -: 32] = k;
        pulse(d, 1'b0, 1'b1, 1'b1);
        wait_drain();
        check("cnt_after_first", 32'(o_result_cnt), 32'd1);

        // AES: only the low 128 bits are streamed.
        d = rand512();
        d[127:0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        @(negedge clk);
        pulse(d, 1'b1, 1'b1, 1'b1);
        wait_drain();

        // Random backpressure on random results.
        ready_pct = 50;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            pulse(rand512(), (r % 3) == 2, 1'b1, 1'b1);
            wait_drain();
        end
        ready_pct = 100;
        @(negedge clk);

        // New done edge exactly on the final handshake: seamless follow-on.
        pulse(rand512(), 1'b0, 1'b1, 1'b1);
        wait_idx(4'd0, 1'b1);
        pulse(rand512(), 1'b0, 1'b1, 1'b0);
        wait_drain();

        // New done edge mid-stream: dropped, overrun set, original continues.
        @(negedge clk);
        pulse(rand512(), 1'b0, 1'b1, 1'b1);
        wait_idx(4'd5, 1'b0);
        pulse(rand512(), 1'b1, 1'b0, 1'b0);
        exp_overrun = 1'b1;
        wait_drain();

        // Reset at idx 7 with done held high across release.
        @(negedge clk);
        pulse(rand512(), 1'b0, 1'b1, 1'b1);
        wait_idx(4'd7, 1'b0);
        d2 = rand512();
        i_core_data     = d2;
        i_aes_or_keccak = 1'b0;
        i_core_done     = 1'b1;
        apply_reset();
        push_result(d2, 1'b0);
        @(negedge clk);
        #1;
        check("post_reset_capture", 32'(o_valid), 32'd1);
        wait_drain();
        i_core_done = 1'b0;
        check("cnt_after_reset", 32'(o_result_cnt), 32'd1);

        // 256 back-to-back AES results wrap the counter.
        @(negedge clk);
        apply_reset();
        @(negedge clk);
        for (int r = 0; r < 256; r++) begin
            if (r == 0) begin
                pulse(rand512(), 1'b1, 1'b1, 1'b1);
            end else begin
                wait_idx(4'd0, 1'b1);
                pulse(rand512(), 1'b1, 1'b1, 1'b0);
            end
        end
        wait_drain();
        check("cnt_wrap", 32'(o_result_cnt), 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
